timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 125 ++++++++++++
 tb/tb_timer_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a maskable interrupt.
// One-shot mode stops and clears EN on expiry; auto-reload mode restarts from PRESET.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | stopped, COUNT held, waiting for CTRL.EN
// ST_LOAD  | copy PRESET into COUNT
// ST_CNT   | decrement COUNT each cycle while EN is set
// ST_INT   | terminal count reached, IRQF set; reload or stop depending on MODE
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'b01;

  state_t      state;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irqf;

  logic ctrl_wr;
  logic ctrl_fields_wr;
  logic preset_wr;

  // Any enabled lane counts as an accepted CTRL write (clears IRQF); only lane 0 holds fields.
  assign ctrl_wr        = we && (addr == ADDR_CTRL) && (byteen != 4'b0000);
  assign ctrl_fields_wr = ctrl_wr && byteen[0];
  assign preset_wr      = we && (addr == ADDR_PRESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= 32'd0;
      count     <= 32'd0;
      irqf      <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (preset_wr && byteen[i]) begin
          preset[8*i +: 8] <= wdata[8*i +: 8];
        end
      end

      // Placed before the FSM so a flag raised in the same cycle is not lost.
      if (ctrl_wr) begin
        irqf <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (ctrl_en) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= 32'd0;
            irqf  <= 1'b1;
            state <= ST_INT;
          end
        end
        ST_INT: begin
          if (ctrl_mode == MODE_AUTO) begin
            irqf  <= 1'b0;
            state <= ST_LOAD;
          end else begin
            ctrl_en <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // After the FSM so a software-written EN overrides the one-shot auto-clear.
      if (ctrl_fields_wr) begin
        ctrl_en   <= wdata[0];
        ctrl_mode <= wdata[2:1];
        ctrl_im   <= wdata[3];
      end
    end
  end

  assign irq = irqf & ctrl_im;

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register-access vector table, hand-written
// corner sequences, and randomized runs compared against an arithmetic timing model.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks;
  int failures;

  timer_counter dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one rising edge; leaves time 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    we = 1'b1; addr = a; byteen = be; wdata = d;
    tick();
    we = 1'b0; byteen = 4'b0000; wdata = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(name, v, exp);
  endtask

  // Timing model: EN written at edge k; t = edges since k. LOAD completes at t=2, then a
  // cycle of M+2 edges (M = max(N,1)) in which COUNT = N-p for p<M, expiry at p==M.
  task automatic run_trial(input int n, input int mode, input bit im, input int cycles);
    int m, per, p;
    bit auto_mode;
    logic [31:0] exp_count;
    logic        exp_irq;
    logic        exp_en;
    logic [31:0] exp_ctrl;
    do_reset();
    wr(2'd1, 4'hF, n);
    wr(2'd0, 4'hF, {28'd0, im, mode[1:0], 1'b1});
    m = (n < 1) ? 1 : n;
    per = m + 2;
    auto_mode = (mode == 1);
    for (int t = 1; t <= cycles; t++) begin
      tick();
      if (t < 2) begin
        exp_count = 32'd0;
        exp_irq   = 1'b0;
      end else begin
        p = auto_mode ? (t - 2) % per : (t - 2);
        exp_count = (p < m) ? n - p : 32'd0;
        exp_irq   = auto_mode ? (im && p == m) : (im && p >= m);
      end
      exp_en   = auto_mode ? 1'b1 : (t < m + 3);
      exp_ctrl = {28'd0, im, mode[1:0], exp_en};
      check_reg("trial_count", 2'd2, exp_count);
      check("trial_irq", {31'd0, irq}, {31'd0, exp_irq});
      check_reg("trial_ctrl", 2'd0, exp_ctrl);
    end
  endtask

  initial begin
    logic [31:0] v;
    checks = 0; failures = 0;
    reset = 1'b0; addr = 2'd0; we = 1'b0; byteen = 4'b0000; wdata = 32'd0;

    // Reset overrides a simultaneous write.
    reset = 1'b1; we = 1'b1; addr = 2'd1; byteen = 4'hF; wdata = 32'h12345678;
    tick();
    reset = 1'b0; we = 1'b0; byteen = 4'h0;
    for (int a = 0; a < 4; a++) begin
      check_reg("reset_rdata", a[1:0], 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

    vecs[0]  = '{1'b1, 2'd1, 4'b0001, 32'hAABBCCDD, 2'd1, 32'h000000DD};
    vecs[1]  = '{1'b1, 2'd1, 4'b1100, 32'h11223344, 2'd1, 32'h112200DD};
    vecs[2]  = '{1'b0, 2'd1, 4'b1111, 32'h00000000, 2'd1, 32'h112200DD};
    vecs[3]  = '{1'b1, 2'd1, 4'b0000, 32'hFFFFFFFF, 2'd1, 32'h112200DD};
    vecs[4]  = '{1'b1, 2'd2, 4'b1111, 32'h12345678, 2'd2, 32'h00000000};
    vecs[5]  = '{1'b1, 2'd3, 4'b1111, 32'hFFFFFFFF, 2'd3, 32'h00000000};
    vecs[6]  = '{1'b0, 2'd0, 4'b0000, 32'h00000000, 2'd1, 32'h112200DD};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 32'hFFFFFFF6, 2'd0, 32'h00000006};
    vecs[8]  = '{1'b1, 2'd0, 4'b1110, 32'h00000000, 2'd0, 32'h00000006};
    vecs[9]  = '{1'b1, 2'd0, 4'b0001, 32'h00000008, 2'd0, 32'h00000008};
    vecs[10] = '{1'b1, 2'd1, 4'b0010, 32'h0000EE00, 2'd1, 32'h1122EEDD};
    for (int i = 0; i < 11; i++) begin
      we = vecs[i].we; addr = vecs[i].addr; byteen = vecs[i].be; wdata = vecs[i].wd;
      tick();
      we = 1'b0; byteen = 4'h0;
      check_reg($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
    end
    check_reg("vec_count_untouched", 2'd2, 32'd0);

    // One-shot, PRESET=5, CTRL=0x9 at edge k.
    do_reset();
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'hF, 32'h9);
    tick(); tick();
    check_reg("os_count_k2", 2'd2, 32'd5);
    tick(); tick(); tick(); tick();
    check_reg("os_count_k6", 2'd2, 32'd1);
    tick();
    check_reg("os_count_k7", 2'd2, 32'd0);
    check("os_irq_k7", {31'd0, irq}, 32'd1);
    tick();
    check_reg("os_ctrl_k8", 2'd0, 32'h8);
    check("os_irq_k8", {31'd0, irq}, 32'd1);
    tick(); tick(); tick();
    check("os_irq_held", {31'd0, irq}, 32'd1);
    wr(2'd0, 4'hF, 32'h8);
    check("os_irq_cleared", {31'd0, irq}, 32'd0);

    // Auto-reload PRESET=3, and PRESET=0 one-shot.
    run_trial(3, 1, 1'b1, 17);
    run_trial(0, 0, 1'b1, 6);

    // Masked interrupt; writing IM=1 afterwards must not expose the cleared flag.
    run_trial(2, 0, 1'b0, 8);
    wr(2'd0, 4'hF, 32'h8);
    check("im0_irq_after_ctrl", {31'd0, irq}, 32'd0);
    tick();
    check("im0_irq_later", {31'd0, irq}, 32'd0);

    // Reset mid-count at COUNT=10.
    do_reset();
    wr(2'd1, 4'hF, 32'd20);
    wr(2'd0, 4'hF, 32'h1);
    for (int i = 0; i < 12; i++) tick();
    check_reg("mid_count10", 2'd2, 32'd10);
    do_reset();
    for (int a = 0; a < 4; a++) begin
      check_reg("mid_reset_rdata", a[1:0], 32'd0);
    end
    check("mid_reset_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check_reg("mid_reset_idle", 2'd2, 32'd0);

    // PRESET rewritten mid-count, then EN cleared: COUNT freezes; next run uses new PRESET.
    wr(2'd1, 4'hF, 32'd20);
    wr(2'd0, 4'hF, 32'h1);
    for (int i = 0; i < 6; i++) tick();
    wr(2'd1, 4'hF, 32'd100);
    check_reg("preset_mid_count", 2'd2, 32'd15);
    wr(2'd0, 4'hF, 32'h0);
    check_reg("en_clear_count", 2'd2, 32'd14);
    for (int i = 0; i < 5; i++) tick();
    check_reg("en_clear_frozen", 2'd2, 32'd14);
    wr(2'd0, 4'hF, 32'h1);
    tick(); tick();
    check_reg("new_preset_loaded", 2'd2, 32'd100);

    // CTRL write coinciding with the one-shot EN clear: written EN wins.
    do_reset();
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    wr(2'd0, 4'hF, 32'h1);
    check_reg("race_ctrl_en", 2'd0, 32'h1);
    tick(); tick();
    check_reg("race_reload", 2'd2, 32'd2);

    // Randomized runs against the timing model.
    for (int r = 0; r < 16; r++) begin
      int n, mode, cyc;
      bit im;
      n    = $urandom_range(0, 12);
      mode = $urandom_range(0, 3);
      im   = 1'($urandom_range(0, 1));
      cyc  = $urandom_range(4, 3 * (n + 3));
      run_trial(n, mode, im, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
